// File: rtl/linebuf_pkg.sv
// Shared types and constants for the row-delay line-buffer sequencer.
package linebuf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FILL,
    GAP,
    STREAM
  } state_t;

  // Edges from pixel acceptance to the registered window pair.
  localparam int unsigned PIPE_LAT = 2;

endpackage

// File: rtl/linebuf_pos_cnt.sv
// Raster position counters: column wraps at width-1 and advances the row.
module linebuf_pos_cnt
  import linebuf_pkg::*;
#(
  parameter int ADD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [ADD_WIDTH-1:0] width,
  input  logic [ADD_WIDTH-1:0] height,
  output logic [ADD_WIDTH-1:0] col,
  output logic [ADD_WIDTH-1:0] row,
  output logic                 last_col,
  output logic                 last_row
);

  assign last_col = (col == width - ADD_WIDTH'(1));
  assign last_row = (row == height - ADD_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (last_col) begin
        col <= '0;
        row <= row + ADD_WIDTH'(1);
      end else begin
        col <= col + ADD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/linebuf_fifo_ctrl.sv
// Row-delay FIFO sequencer emitting (current, row-above) pixel pairs.
// Define LINEBUF_TOP_PAD_EN to also emit row-0 pairs with a zero upper pixel.
module linebuf_fifo_ctrl
  import linebuf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_SIZE  = 10,
  parameter int ADD_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADD_WIDTH-1:0]  ifm_width,
  input  logic [ADD_WIDTH-1:0]  ifm_height,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  fifo_wr_en,
  output logic                  fifo_wr_inc,
  output logic                  fifo_wr_clr,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_inc,
  output logic                  fifo_rd_clr,
  output logic [DATA_WIDTH-1:0] fifo_din,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  win_valid,
  output logic [DATA_WIDTH-1:0] win_cur,
  output logic [DATA_WIDTH-1:0] win_up,
  output logic [ADD_WIDTH-1:0]  win_col,
  output logic [ADD_WIDTH-1:0]  win_row,
  output logic                  done,
  output logic                  cfg_err
);

`ifdef LINEBUF_TOP_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  state_t                              state;
  logic [ADD_WIDTH-1:0]                w_q, h_q, col, row;
  logic                                last_col, last_row, accept, cfg_ok;
  logic [PIPE_LAT-1:0]                 p_val, p_pad, p_last;
  logic [PIPE_LAT-1:0][DATA_WIDTH-1:0] p_data;
  logic [PIPE_LAT-1:0][ADD_WIDTH-1:0]  p_col, p_row;

  assign accept      = pix_valid & pix_ready;
  assign cfg_ok      = (ifm_width != '0) && (int'(ifm_width) <= FIFO_SIZE) && (ifm_height != '0);
  assign fifo_wr_inc = fifo_wr_en;
  assign fifo_rd_inc = fifo_rd_en;
  assign fifo_din    = p_data[0];

  linebuf_pos_cnt #(.ADD_WIDTH(ADD_WIDTH)) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == CLR),
    .inc      (accept),
    .width    (w_q),
    .height   (h_q),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      pix_ready   <= 1'b0;
      fifo_wr_en  <= 1'b0;
      fifo_rd_en  <= 1'b0;
      fifo_wr_clr <= 1'b1;
      fifo_rd_clr <= 1'b1;
      cfg_err     <= 1'b0;
    end else begin
      fifo_wr_en  <= 1'b0;
      fifo_rd_en  <= 1'b0;
      fifo_wr_clr <= 1'b0;
      fifo_rd_clr <= 1'b0;
      cfg_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              w_q         <= ifm_width;
              h_q         <= ifm_height;
              fifo_wr_clr <= 1'b1;
              fifo_rd_clr <= 1'b1;
              state       <= CLR;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        CLR: begin
          pix_ready <= 1'b1;
          state     <= FILL;
        end
        FILL, STREAM: begin
          if (accept) begin
            fifo_wr_en <= 1'b1;
            fifo_rd_en <= (state == STREAM);
            if (last_col) begin
              pix_ready <= 1'b0;
              state     <= last_row ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          // The row's last write lands during GAP, so rewinding both pointers
          // one cycle later cannot collide with an enable.
          fifo_wr_clr <= 1'b1;
          fifo_rd_clr <= 1'b1;
          pix_ready   <= 1'b1;
          state       <= STREAM;
        end
        default: begin
          pix_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_val     <= '0;
      p_pad     <= '0;
      p_last    <= '0;
      p_data    <= '0;
      p_col     <= '0;
      p_row     <= '0;
      win_valid <= 1'b0;
      win_cur   <= '0;
      win_up    <= '0;
      win_col   <= '0;
      win_row   <= '0;
      done      <= 1'b0;
    end else begin
      p_val                  <= {p_val[PIPE_LAT-2:0], accept & ((state == STREAM) | PAD_EN)};
      p_pad[PIPE_LAT-1:1]    <= p_pad[PIPE_LAT-2:0];
      p_last[PIPE_LAT-1:1]   <= p_last[PIPE_LAT-2:0];
      p_data[PIPE_LAT-1:1]   <= p_data[PIPE_LAT-2:0];
      p_col[PIPE_LAT-1:1]    <= p_col[PIPE_LAT-2:0];
      p_row[PIPE_LAT-1:1]    <= p_row[PIPE_LAT-2:0];
      // Stage 0 data doubles as fifo_din, so it only moves on acceptance.
      if (accept) begin
        p_data[0] <= pix_data;
        p_pad[0]  <= (state == FILL);
        p_last[0] <= last_col & last_row;
        p_col[0]  <= col;
        p_row[0]  <= row;
      end
      win_valid <= p_val[PIPE_LAT-1];
      win_cur   <= p_data[PIPE_LAT-1];
      win_up    <= p_pad[PIPE_LAT-1] ? '0 : fifo_dout;
      win_col   <= p_col[PIPE_LAT-1];
      win_row   <= p_row[PIPE_LAT-1];
      done      <= p_val[PIPE_LAT-1] & p_last[PIPE_LAT-1];
    end
  end

endmodule

// File: doc/linebuf_fifo_ctrl.md
# linebuf_fifo_ctrl

Sequencer that drives one row-delay line-buffer FIFO in the CNN datapath. It accepts a raster-order input-feature-map pixel stream and generates the FIFO write/read/clear/increment controls so that the FIFO returns the pixel one row above the current one. It then emits aligned vertical pixel pairs (current, row-above) to the convolution window stage. It sits directly upstream of the asynchronous line-buffer FIFO, with both FIFO clocks tied to `clk`.

## Interface
Parameters:
- `DATA_WIDTH`, 16, pixel width.
- `FIFO_SIZE`, 10, FIFO depth; maximum row length.
- `ADD_WIDTH`, 4, counter width; must satisfy 2^ADD_WIDTH > FIFO_SIZE.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that launches a frame.
- `ifm_width`  in  ADD_WIDTH  row length W; sampled on `start`.
- `ifm_height`  in  ADD_WIDTH  row count H; sampled on `start`.
- `pix_valid` / `pix_data`  in  1 / DATA_WIDTH  input pixel stream.
- `pix_ready`  out  1  pixel accept; a pixel transfers when `pix_valid & pix_ready`.
- `fifo_wr_en`, `fifo_wr_inc`, `fifo_wr_clr`  out  1 each  FIFO write controls.
- `fifo_rd_en`, `fifo_rd_inc`, `fifo_rd_clr`  out  1 each  FIFO read controls.
- `fifo_din`  out  DATA_WIDTH  FIFO write data.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data.
- `win_valid`  out  1  window pair valid.
- `win_cur`, `win_up`  out  DATA_WIDTH  current pixel and row-above pixel.
- `win_col`, `win_row`  out  ADD_WIDTH  coordinates of `win_cur`.
- `done`  out  1  end-of-frame pulse.
- `cfg_err`  out  1  pulse on a rejected `start`.

## Operation
- All outputs are registered.
- Reset values: all outputs 0, except `fifo_wr_clr` = 1 and `fifo_rd_clr` = 1. Reset from any state returns to IDLE and discards frame progress.
- States:
  - IDLE: `pix_ready`=0. On `start` with 1≤W≤FIFO_SIZE and H≥1, capture W and H, then go to CLR. Otherwise pulse `cfg_err` and stay in IDLE.
  - CLR: one cycle; both clears asserted; then FILL.
  - FILL (row 0): `pix_ready`=1. Each accepted pixel produces a write only.
  - GAP: one cycle with `pix_ready`=0. It is entered after the last pixel of each row is accepted (column W-1). The clears are asserted in the cycle after GAP.
  - STREAM (rows 1..H-1): `pix_ready`=1. Each accepted pixel produces a write and a read at the same pointer. The FIFO returns the old contents, i.e. row r-1.
  - After the last pixel of row H-1, go to IDLE. `done` pulses once, coincident with the final `win_valid`.
- `fifo_wr_inc` = `fifo_wr_en` and `fifo_rd_inc` = `fifo_rd_en` in every cycle.
- Column counter counts 0..W-1 and wraps to 0; the row counter increments on that wrap. Counters are unsigned ADD_WIDTH, with no saturation.
- `pix_valid` low in FILL or STREAM: no enables are asserted and no `win_valid` follows. Stalls of any length are allowed.
- `start` outside IDLE is ignored.
- H=1: FILL, then IDLE. No reads are issued.

## Timing
- Pixel accepted at edge k → `fifo_din` and the enables are high during cycle k+1, and the FIFO acts at edge k+1.
- `win_valid`, `win_cur` (pixel delayed 2 cycles) and `win_up` (sampled from `fifo_dout`) are registered at edge k+2. Latency from acceptance is 2 cycles.
- Clears are high for exactly one cycle. That cycle never coincides with an enable, so no write is lost to the FIFO's clear priority.
- Throughput: W pixels per W+1 cycles in steady state.

## Configuration
- `LINEBUF_TOP_PAD_EN` defined: FILL pixels also produce `win_valid`, with `win_up` forced to 0 (zero padding for row 0). `win_row` starts at 0.
- Not defined: no `win_valid` during FILL. The first window pair is row 1.

## Structure
- Shared package `linebuf_pkg`: state enum (IDLE, CLR, FILL, GAP, STREAM) and the 2-cycle latency constant.
- One sub-module, `linebuf_pos_cnt`: column/row counters with wrap and last-pixel flags.

## Test plan
- W=4, H=3, pixels 1..12, `pix_valid` held high → pairs (cur,up) = (5,1)…(8,4), (9,5)…(12,8). `done` with the pair (12,8). One `pix_ready` low cycle per row.
- Same frame with `pix_valid` toggling every other cycle → identical pairs and coordinates.
- `start` with W=0, W=11, or H=0 → `cfg_err` pulse, state stays IDLE, no FIFO activity.
- `rst` asserted mid-row 1 → next cycle all outputs at reset values. A fresh W=2, H=2 frame then yields (3,1), (4,2).
- H=1, W=FIFO_SIZE=10 → 10 writes, zero reads. `done` is asserted only with `LINEBUF_TOP_PAD_EN` (10 pairs with `win_up`=0); without it, no `win_valid`.
- `start` pulsed during STREAM → ignored; the frame completes unchanged.
